// File: rtl/seq_detect_prog.sv
// -----------------------------------------------------------------------------
// seq_detect_prog : programmable serial pattern detector (Moore output).
// The pattern (up to MAX_LEN bits, right-aligned, MSB of the active length
// received first), its length and the overlap mode are loaded with cfg_load.
// Reset loads RST_PATTERN / RST_LEN with overlap enabled, so the default build
// behaves as a 110110 overlapping detector.
// Optional feature: define SEQ_DETECT_MATCH_CNT_EN to add the saturating
// match_cnt output and its counter; without it the port and logic are absent.
// -----------------------------------------------------------------------------
module seq_detect_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 8'b0011_0110,
    parameter int                 RST_LEN     = 6,
    parameter int                 CNT_W       = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     x,
    input  logic                     en,
    input  logic                     cfg_load,
    input  logic [MAX_LEN-1:0]       cfg_pattern,
    input  logic [$clog2(MAX_LEN):0] cfg_len,
    input  logic                     cfg_overlap,
    output logic                     z
`ifdef SEQ_DETECT_MATCH_CNT_EN
    ,
    output logic [CNT_W-1:0]         match_cnt
`endif
);

    localparam int                 LEN_W     = $clog2(MAX_LEN) + 1;
    localparam logic [LEN_W-1:0]   MAX_LEN_L = LEN_W'(MAX_LEN);

    // Reject illegal parameterisations at elaboration time.
    if (MAX_LEN < 2 || MAX_LEN > 32) begin : g_bad_max_len
        $error("seq_detect_prog: MAX_LEN must be in 2..32");
    end
    if (RST_LEN < 0 || RST_LEN > MAX_LEN) begin : g_bad_rst_len
        $error("seq_detect_prog: RST_LEN must be in 0..MAX_LEN");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detect_prog: CNT_W must be at least 1");
    end

    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic               ovl_q,  ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               z_q,    z_d;

    logic [MAX_LEN-1:0] len_mask;
    logic [MAX_LEN-1:0] hist_shift;
    logic [LEN_W-1:0]   fill_inc;
    logic               hit;
    logic               match;

    // Mask selecting the active low len_q bits of history and pattern.
    always_comb begin
        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask[i] = (LEN_W'(i) < len_q);
        end
    end

    // Candidate history/fill after sampling x, and the match decision on it.
    always_comb begin
        hist_shift = {hist_q[MAX_LEN-2:0], x};
        fill_inc   = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + LEN_W'(1);
        hit        = (len_q != '0) && (fill_inc >= len_q) &&
                     ((hist_shift & len_mask) == (pat_q & len_mask));
        match      = !cfg_load && en && hit;
    end

    // Next-state: configuration load beats sampling; en=0 holds everything.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path leaves it unassigned and no latch is inferred.
        pat_d  = pat_q;
        len_d  = len_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        z_d    = z_q;
        if (cfg_load) begin
            pat_d  = cfg_pattern;
            len_d  = (cfg_len > MAX_LEN_L) ? MAX_LEN_L : cfg_len;
            ovl_d  = cfg_overlap;
            hist_d = '0;
            fill_d = '0;
            z_d    = 1'b0;
        end else if (en) begin
            hist_d = hist_shift;
            // Non-overlap restarts the fill so the next match needs len fresh bits.
            fill_d = (hit && !ovl_q) ? '0 : fill_inc;
            z_d    = hit;
        end
    end

    // State registers with asynchronous active-low reset to the default config.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of evaluation order.
        if (!rst) begin
            pat_q  <= RST_PATTERN;
            len_q  <= LEN_W'(RST_LEN);
            ovl_q  <= 1'b1;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            len_q  <= len_d;
            ovl_q  <= ovl_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
        end
    end

    assign z = z_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating match counter, cleared by a configuration load.
    always_comb begin
        cnt_d = cnt_q;
        if (cfg_load) begin
            cnt_d = '0;
        end else if (match && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_cnt = cnt_q;
`else
    // Without the counter the match strobe has no consumer.
    logic unused_match;
    assign unused_match = match;
`endif

endmodule

// File: tb/tb_seq_detect_prog.sv
// -----------------------------------------------------------------------------
// tb_seq_detect_prog : scoreboard bench for seq_detect_prog. The driver pushes
// the hand-computed z (and match count) expected after each clock edge; the
// monitor pops one entry per falling edge and compares. Reset pulses are
// checked directly between edges. Counter checks follow
// SEQ_DETECT_MATCH_CNT_EN.
// -----------------------------------------------------------------------------
module tb_seq_detect_prog;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    typedef struct {
        logic  z;
        int    cnt;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   exp_cnt   = 0;

    logic         clk         = 1'b0;
    logic         rst         = 1'b1;
    logic         x           = 1'b0;
    logic         en          = 1'b0;
    logic         cfg_load    = 1'b0;
    logic [7:0]   cfg_pattern = '0;
    logic [3:0]   cfg_len     = '0;
    logic         cfg_overlap = 1'b0;
    logic         z;
`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] match_cnt;
`endif

    seq_detect_prog #(
        .MAX_LEN(MAX_LEN),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .x          (x),
        .en         (en),
        .cfg_load   (cfg_load),
        .cfg_pattern(cfg_pattern),
        .cfg_len    (cfg_len),
        .cfg_overlap(cfg_overlap),
        .z          (z)
`ifdef SEQ_DETECT_MATCH_CNT_EN
        ,
        .match_cnt  (match_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // One sampling cycle: inputs change on the falling edge, expectation
    // is queued after the rising edge that consumes them.
    task automatic step(input logic xi, input logic eni, input logic ez, input string tag);
        @(negedge clk);
        x        = xi;
        en       = eni;
        cfg_load = 1'b0;
        @(posedge clk);
        if (eni && ez) exp_cnt = (exp_cnt >= CNT_MAX) ? CNT_MAX : exp_cnt + 1;
        exp_q.push_back('{ez, exp_cnt, tag});
    endtask

    // Feed n bits (first bit = xs[n-1]) with en=1 and per-bit expected z.
    task automatic run(input logic [31:0] xs, input logic [31:0] zs, input int n, input string tag);
        for (int i = n - 1; i >= 0; i--) begin
            step(xs[i], 1'b1, zs[i], $sformatf("%s.b%0d", tag, n - i));
        end
    endtask

    // Configuration load with en=1 and x=1 present to show they are ignored.
    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o, input string tag);
        @(negedge clk);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        en          = 1'b1;
        x           = 1'b1;
        @(posedge clk);
        exp_cnt = 0;
        exp_q.push_back('{1'b0, 0, tag});
    endtask

    // Reset pulse strictly between clock edges; outputs must clear at once.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #1;
        en  = 1'b0;
        rst = 1'b0;
        #1;
        check({tag, ".z"}, 32'(z), 32'd0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
        check({tag, ".cnt"}, 32'(match_cnt), 32'd0);
`endif
        exp_cnt = 0;
        #1;
        rst = 1'b1;
    endtask

    // Monitor: one expected entry per rising edge, compared mid-cycle.
    initial begin
        exp_t it;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                it = exp_q.pop_front();
                check({it.tag, ".z"}, 32'(z), 32'(it.z));
`ifdef SEQ_DETECT_MATCH_CNT_EN
                check({it.tag, ".cnt"}, 32'(match_cnt), 32'(it.cnt));
`endif
            end
        end
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        check("por.z", 32'(z), 32'd0);
`ifdef SEQ_DETECT_MATCH_CNT_EN
        check("por.cnt", 32'(match_cnt), 32'd0);
`endif
        @(negedge clk);
        #1 rst = 1'b1;

        // Default 110110 overlapping detector.
        run(32'b110110110, 32'b000001001, 9, "dflt_ovl");

        // Non-overlapping 110110.
        cfg(8'b0011_0110, 4'd6, 1'b0, "cfg_novl");
        run(32'b110110110110, 32'b000001000001, 12, "novl");

        // en=0 holds history and z while x toggles.
        cfg(8'b0011_0110, 4'd6, 1'b1, "cfg_dflt");
        run(32'b1101, 32'b0000, 4, "en_pre");
        for (int i = 0; i < 5; i++) step(1'(i % 2), 1'b0, 1'b0, $sformatf("en_off%0d", i));
        run(32'b10, 32'b01, 2, "en_post");
        step(1'b0, 1'b0, 1'b1, "z_hold0");
        step(1'b1, 1'b0, 1'b1, "z_hold1");
        run(32'b1, 32'b0, 1, "z_drop");

        // Short overlapping pattern 101.
        cfg(8'b0000_0101, 4'd3, 1'b1, "cfg_101");
        run(32'b10101, 32'b00101, 5, "p101");

        // Length 0 disables the detector even with an all-zero pattern.
        cfg(8'b0000_0000, 4'd0, 1'b1, "cfg_len0");
        run(32'b10100, 32'b00000, 5, "len0");

        // Oversized length clamps to MAX_LEN: match only once 8 bits are in.
        cfg(8'b1010_0110, 4'd15, 1'b1, "cfg_clamp");
        run(32'b10100110, 32'b00000001, 8, "clamp");

        // Length 1, non-overlap: every 1 matches; counter saturates at 3.
        cfg(8'b0000_0001, 4'd1, 1'b0, "cfg_len1");
        run(32'b101111, 32'b101111, 6, "len1");

        // Reset restores defaults; an active z clears asynchronously.
        reset_pulse("rst_idle");
        run(32'b110110, 32'b000001, 6, "rst_dflt");
        reset_pulse("rst_hit");

        // Reset mid-sequence discards partial history.
        run(32'b11011, 32'b00000, 5, "pre_rst");
        reset_pulse("rst_mid");
        run(32'b0, 32'b0, 1, "post_rst");
        run(32'b110110, 32'b000001, 6, "after_rst");

        // Drain the scoreboard within a bounded number of cycles.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
